// File: rtl/fir_pkg.sv
// Shared types and sizing constants for the FIR sequencing controller.
package fir_pkg;

   localparam int NTAPS = 4;
   localparam int CW    = 8;
   localparam int DW    = 8;
   localparam int NBITS = NTAPS * CW;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } fir_state_t;

endpackage

// File: rtl/fir_coef_ser.sv
// Parallel-load coefficient serialiser: shifts a latched set out MSB first,
// one bit per cycle, and flags the final bit.
module fir_coef_ser #(
   parameter int NBITS = fir_pkg::NBITS
) (
   input  logic             ph1,
   input  logic             resetb,
   input  logic             load,
   input  logic [NBITS-1:0] data,
   output logic             shiftIn,
   output logic             shiftClkEn,
   output logic             done
);

   localparam int CNTW = $clog2(NBITS);
   localparam logic [CNTW-1:0] LAST = CNTW'(NBITS - 1);

   logic [NBITS-1:0] sreg_q, sreg_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             busy_q, busy_d;

   assign shiftIn    = sreg_q[NBITS-1];
   assign shiftClkEn = busy_q;
   assign done       = busy_q && (cnt_q == LAST);

   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (load) begin
         sreg_d = data;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         sreg_d = {sreg_q[NBITS-2:0], 1'b0};
         cnt_d  = cnt_q + 1'b1;
         if (done) busy_d = 1'b0;
      end
   end

   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         sreg_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencing controller: loads coefficients into the datapath chain,
// then paces buffered samples at a fixed period and tracks result validity.
module fir_ctrl #(
   parameter int NTAPS  = fir_pkg::NTAPS,
   parameter int CW     = fir_pkg::CW,
   parameter int DW     = fir_pkg::DW,
   parameter int PERIOD = 4,
   parameter int LAT    = 2
) (
   input  logic                ph1,
   input  logic                resetb,
   input  logic                coef_valid,
   output logic                coef_ready,
   input  logic [NTAPS*CW-1:0] coef_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DW-1:0]       in_data,
   output logic [DW-1:0]       a,
   output logic                enData,
   output logic                shiftIn,
   output logic                shiftClkEn,
   output logic                y_valid,
   output logic                underrun,
   output logic                loaded
);

   import fir_pkg::*;

   localparam int NB   = NTAPS * CW;
   localparam int PCW  = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam logic [PCW-1:0] P_LAST = PCW'(PERIOD - 1);
   localparam logic [PCW-1:0] P_PRE  = PCW'(PERIOD - 2);

   fir_state_t     state_q, state_d;
   logic [PCW-1:0] pcnt_q, pcnt_d;
   logic [DW-1:0]  buf_q, buf_d;
   logic           bufv_q, bufv_d;
   logic [DW-1:0]  a_q, a_d;
   logic           en_q, en_d;
   logic           un_q, un_d;
   logic [LAT-1:0] vq_q, vq_d;
   logic           loaded_q, loaded_d;

   logic c_hs, s_hs, ev, push, ser_done;

   assign coef_ready = (state_q != LOAD);
   assign in_ready   = (state_q == RUN) && !bufv_q;
   assign c_hs       = coef_valid && coef_ready;
   assign s_hs       = in_valid && in_ready;
   // Strobe actions land on the edge that raises enData; reload wins.
   assign ev   = (state_q == RUN) && (pcnt_q == P_PRE) && !c_hs;
   assign push = en_q && !un_q;

   fir_coef_ser #(.NBITS(NB)) u_ser (
      .ph1       (ph1),
      .resetb    (resetb),
      .load      (c_hs),
      .data      (coef_data),
      .shiftIn   (shiftIn),
      .shiftClkEn(shiftClkEn),
      .done      (ser_done)
   );

   always_comb begin
      state_d  = state_q;
      pcnt_d   = pcnt_q;
      buf_d    = buf_q;
      bufv_d   = bufv_q;
      a_d      = a_q;
      en_d     = 1'b0;
      un_d     = 1'b0;
      loaded_d = loaded_q;
      vq_d[0]  = push;
      for (int i = 1; i < LAT; i++) vq_d[i] = vq_q[i-1];
      unique case (state_q)
         IDLE: begin
            if (c_hs) state_d = LOAD;
         end
         LOAD: begin
            loaded_d = 1'b0;
            if (ser_done) begin
               state_d  = RUN;
               loaded_d = 1'b1;
            end
         end
         RUN: begin
            pcnt_d = (pcnt_q == P_LAST) ? '0 : pcnt_q + 1'b1;
            if (ev) begin
               en_d   = 1'b1;
               a_d    = bufv_q ? buf_q : '0;
               un_d   = !bufv_q;
               bufv_d = 1'b0;
            end
            if (s_hs) begin
               buf_d  = in_data;
               bufv_d = 1'b1;
            end
            if (c_hs) begin
               state_d  = LOAD;
               pcnt_d   = '0;
               vq_d     = '0;
               loaded_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         state_q  <= IDLE;
         pcnt_q   <= '0;
         buf_q    <= '0;
         bufv_q   <= 1'b0;
         a_q      <= '0;
         en_q     <= 1'b0;
         un_q     <= 1'b0;
         vq_q     <= '0;
         loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pcnt_q   <= pcnt_d;
         buf_q    <= buf_d;
         bufv_q   <= bufv_d;
         a_q      <= a_d;
         en_q     <= en_d;
         un_q     <= un_d;
         vq_q     <= vq_d;
         loaded_q <= loaded_d;
      end
   end

   assign a        = a_q;
   assign enData   = en_q;
   assign underrun = un_q;
   assign y_valid  = vq_q[LAT-1];
   assign loaded   = loaded_q;

endmodule
